// File: rtl/spi_led_ctrl_pkg.sv
// spi_led_pkg: shared constants for the SPI-driven LED PWM controller.
//   PWM_WIDTH : width of the PWM counter and brightness registers
//   OP_*      : command opcodes carried in data[7:6] of a command byte
//   state_e   : command decoder FSM encoding
package spi_led_pkg;

    localparam int PWM_WIDTH = 8;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_SET_ALL = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_DATA  = 2'd1,
        ALL_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/spi_led_ctrl_if.sv
// spi_led_ctrl_if: byte-level link from an SPI receiver to the LED controller.
//   data     : received byte (asynchronous to the controller clock)
//   data_rdy : byte-valid level (asynchronous)
//   nsel     : SPI chip select, active low (asynchronous)
// master = SPI receiver side, slave = spi_led_ctrl side.
interface spi_led_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] data;
    logic                 data_rdy;
    logic                 nsel;

    modport master (output data, data_rdy, nsel);
    modport slave  (input  data, data_rdy, nsel);
endinterface

// File: rtl/spi_led_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
//   clk, nreset : destination clock, async active-low reset
//   d           : asynchronous input
//   q           : synchronised output; both flops reset to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: decodes command bytes from an SPI receiver and drives
// NUM_LEDS PWM outputs from per-channel 8-bit brightness registers.
//   clk, nreset : system clock, async active-low reset
//   spi         : slave side of spi_led_ctrl_if (data, data_rdy, nsel)
//   led         : registered PWM outputs, led[i] = (pwm_cnt < bright[i])
//   cmd_err     : one-clk pulse when a WRITE targets a non-existent LED
// Commands: op=data[7:6], addr=data[2:0]. WRITE and SET_ALL take one data
// byte; NOP and CLEAR are single-byte. Deasserting nsel drops any partial
// command.
module spi_led_ctrl
    import spi_led_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NUM_LEDS  = 8
) (
    input  logic                clk,
    input  logic                nreset,
    spi_led_ctrl_if.slave       spi,
    output logic [NUM_LEDS-1:0] led,
    output logic                cmd_err
);

    logic                 rdy_s, nsel_s;
    logic                 rdy_q;
    logic [1:0]           settle_cnt;
    logic                 settled;
    logic                 byte_valid;
    logic [DATAWIDTH-1:0] rx_byte;
    logic [1:0]           op;
    logic [2:0]           addr;
    logic [2:0]           addr_q;
    logic                 addr_ok;
    state_e               state_q, state_d;
    logic                 addr_ld, wr_one, wr_all, clr_all, err_d;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] bright;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_rdy (
        .clk(clk), .nreset(nreset), .d(spi.data_rdy), .q(rdy_s)
    );
    sync_2ff #(.RST_VAL(1'b1)) u_sync_nsel (
        .clk(clk), .nreset(nreset), .d(spi.nsel), .q(nsel_s)
    );

    // The synchroniser output only reflects the pin two edges after reset
    // release. Until then the edge detector holds its history at 1, so a
    // data_rdy level already high across reset never looks like a new edge.
    assign settled = (settle_cnt == 2'd2);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            settle_cnt <= 2'd0;
            rdy_q      <= 1'b1;
        end else begin
            if (!settled)
                settle_cnt <= settle_cnt + 2'd1;
            rdy_q <= settled ? rdy_s : 1'b1;
        end
    end

    assign byte_valid = settled & rdy_s & ~rdy_q;

    // data is held stable by the source for several clks after data_rdy,
    // so it is safe to read directly in the byte_valid cycle.
    assign rx_byte = spi.data;
    assign op      = rx_byte[7:6];
    assign addr    = rx_byte[2:0];
    assign addr_ok = (int'(addr_q) < NUM_LEDS);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            addr_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            if (addr_ld)
                addr_q <= addr;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_ld = 1'b0;
        wr_one  = 1'b0;
        wr_all  = 1'b0;
        clr_all = 1'b0;
        err_d   = 1'b0;
        // Deselect overrides everything, including a byte arriving this cycle.
        if (nsel_s) begin
            state_d = IDLE;
        end else if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    case (op)
                        OP_WRITE: begin
                            addr_ld = 1'b1;
                            state_d = WR_DATA;
                        end
                        OP_SET_ALL: state_d = ALL_DATA;
                        OP_CLEAR:   clr_all = 1'b1;
                        default:    state_d = IDLE;
                    endcase
                end
                WR_DATA: begin
                    if (addr_ok)
                        wr_one = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = IDLE;
                end
                ALL_DATA: begin
                    wr_all  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bright  <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= err_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (clr_all)
                    bright[i] <= '0;
                else if (wr_all || (wr_one && int'(addr_q) == i))
                    bright[i] <= rx_byte[PWM_WIDTH-1:0];
            end
        end
    end

    // Free-running PWM; new brightness applies mid-period.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int i = 0; i < NUM_LEDS; i++)
                led[i] <= (pwm_cnt < bright[i]);
        end
    end

endmodule

// File: tb/tb_spi_led_ctrl.sv
module tb_spi_led_ctrl;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] led8;
    logic [3:0] led4;
    logic       err8, err4;

    int checks = 0;
    int errors = 0;
    int err8_cnt = 0;
    int err4_cnt = 0;
    int c8[8];
    int c4[4];
    logic [7:0] tb_pwm;

    spi_led_ctrl_if #(.DATAWIDTH(8)) spi_bus ();

    spi_led_ctrl #(.DATAWIDTH(8), .NUM_LEDS(8)) u_dut8 (
        .clk(clk), .nreset(nreset), .spi(spi_bus), .led(led8), .cmd_err(err8)
    );
    spi_led_ctrl #(.DATAWIDTH(8), .NUM_LEDS(4)) u_dut4 (
        .clk(clk), .nreset(nreset), .spi(spi_bus), .led(led4), .cmd_err(err4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (err8) err8_cnt <= err8_cnt + 1;
        if (err4) err4_cnt <= err4_cnt + 1;
    end

    // Reference PWM phase: counts clk edges since reset release.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) tb_pwm <= 8'd0;
        else         tb_pwm <= tb_pwm + 8'd1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        spi_bus.data = b;
        @(negedge clk);
        spi_bus.data_rdy = 1'b1;
        repeat (6) @(negedge clk);
        spi_bus.data_rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic measure();
        for (int i = 0; i < 8; i++) c8[i] = 0;
        for (int i = 0; i < 4; i++) c4[i] = 0;
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) c8[i] += int'(led8[i]);
            for (int i = 0; i < 4; i++) c4[i] += int'(led4[i]);
        end
    endtask

    task automatic chk_all(input string tag, input int exp8[8], input int exp4[4]);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_led8[%0d]", tag, i), c8[i], exp8[i]);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_led4[%0d]", tag, i), c4[i], exp4[i]);
    endtask

    initial begin
        int bad;
        int e4_base;
        logic [7:0] pwm_prev;
        logic [7:0] exp_full;

        nreset = 1'b0;
        spi_bus.nsel = 1'b1;
        spi_bus.data_rdy = 1'b0;
        spi_bus.data = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_led8", int'(led8), 0);
        chk("reset_led4", int'(led4), 0);
        chk("reset_err", int'(err8 | err4), 0);
        nreset = 1'b1;

        // Idle for 600 clk: nothing lights, no errors
        bad = 0;
        repeat (600) begin
            @(negedge clk);
            if (led8 !== 8'd0 || led4 !== 4'd0) bad++;
        end
        chk("idle_led_cycles", bad, 0);
        chk("idle_err_cnt", err8_cnt + err4_cnt, 0);

        // WRITE led3 = 0x80
        spi_bus.nsel = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h43);
        send_byte(8'h80);
        measure();
        chk_all("wr3", '{0, 0, 0, 128, 0, 0, 0, 0}, '{0, 0, 0, 128});

        // SET_ALL 0xFF, then CLEAR with latency check
        send_byte(8'h80);
        send_byte(8'hFF);
        measure();
        chk_all("setall", '{255, 255, 255, 255, 255, 255, 255, 255}, '{255, 255, 255, 255});

        @(negedge clk);
        spi_bus.data = 8'hC0;
        @(negedge clk);
        spi_bus.data_rdy = 1'b1;
        repeat (3) @(negedge clk);
        // edge 3 writes the registers; led at that edge still uses old value
        pwm_prev = tb_pwm - 8'd1;
        exp_full = (pwm_prev != 8'hFF) ? 8'hFF : 8'h00;
        chk("clear_edge3_led8", int'(led8), int'(exp_full));
        @(negedge clk);
        chk("clear_edge4_led8", int'(led8), 0);
        chk("clear_edge4_led4", int'(led4), 0);
        repeat (3) @(negedge clk);
        spi_bus.data_rdy = 1'b0;
        repeat (4) @(negedge clk);
        measure();
        chk_all("clear", '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0});

        // WRITE addr 6: valid for 8 LEDs, out of range for 4 LEDs
        e4_base = err4_cnt;
        send_byte(8'h46);
        send_byte(8'h55);
        chk("bad_addr_err4", err4_cnt - e4_base, 1);
        chk("bad_addr_err8", err8_cnt, 0);
        measure();
        chk_all("addr6", '{0, 0, 0, 0, 0, 0, 85, 0}, '{0, 0, 0, 0});
        // decoder must be back in IDLE: next pair is a normal write
        send_byte(8'h41);
        send_byte(8'h20);
        measure();
        chk_all("wr1", '{0, 32, 0, 0, 0, 0, 85, 0}, '{0, 32, 0, 0});

        // Abort via nsel after a WRITE command byte
        send_byte(8'h42);
        spi_bus.nsel = 1'b1;
        repeat (5) @(negedge clk);
        spi_bus.nsel = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h81);
        measure();
        chk_all("abort", '{0, 32, 0, 0, 0, 0, 85, 0}, '{0, 32, 0, 0});
        send_byte(8'h10);
        measure();
        chk_all("abort_all", '{16, 16, 16, 16, 16, 16, 16, 16}, '{16, 16, 16, 16});
        chk("abort_err8", err8_cnt, 0);

        // Reset mid-command, with data_rdy held high across release
        send_byte(8'h41);
        nreset = 1'b0;
        spi_bus.data = 8'h55;
        spi_bus.data_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_led8", int'(led8), 0);
        nreset = 1'b1;
        repeat (6) @(negedge clk);
        spi_bus.data_rdy = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h10);
        measure();
        chk_all("rst_nop", '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0});
        send_byte(8'h43);
        send_byte(8'h40);
        measure();
        chk_all("rst_wr3", '{0, 0, 0, 64, 0, 0, 0, 0}, '{0, 0, 0, 64});
        chk("final_err8", err8_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_led_ctrl.md
SPI_LED_CTRL -- requirements
Module: spi_led_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8; SPI byte width, fixed at 8 for this command set.
REQ-002 SHALL have parameter NUM_LEDS, default 8; number of PWM channels, 1..8.
REQ-003 SHALL have port clk, input, 1; system clock, the only clock.
REQ-004 SHALL have port nreset, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port data, input, DATAWIDTH; received byte from the SPI receiver, asynchronous to clk.
REQ-006 SHALL have port data_rdy, input, 1; byte-valid level from the SPI receiver, asynchronous to clk.
REQ-007 SHALL have port nsel, input, 1; SPI chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port led, output, NUM_LEDS; registered PWM outputs.
REQ-009 SHALL have port cmd_err, output, 1; one-clk pulse on an invalid command or address.

Function
REQ-010 SHALL synchronise data_rdy and nsel through two flops each.
REQ-011 SHALL raise an internal byte_valid pulse for one clk on a synchronised data_rdy rising edge, one pulse per edge.
REQ-012 SHALL sample data in the byte_valid cycle; the source SHALL hold data stable for at least 4 clk after data_rdy rises.
REQ-013 SHALL decode command byte fields: op = data[7:6], addr = data[2:0], data[5:3] ignored.
REQ-014 SHALL implement an FSM with states IDLE, WR_DATA and ALL_DATA.
REQ-015 IDLE, byte_valid, op=00 (NOP): SHALL stay in IDLE with no effect.
REQ-016 IDLE, byte_valid, op=01 (WRITE): SHALL latch addr and go to WR_DATA.
REQ-017 IDLE, byte_valid, op=10 (SET_ALL): SHALL go to ALL_DATA.
REQ-018 IDLE, byte_valid, op=11 (CLEAR): SHALL set all brightness registers to 0 on the next edge and stay in IDLE.
REQ-019 WR_DATA, byte_valid: SHALL write bright[addr] = data if addr < NUM_LEDS, else discard the byte and pulse cmd_err; SHALL then return to IDLE.
REQ-020 ALL_DATA, byte_valid: SHALL write every bright[i] = data and return to IDLE.
REQ-021 Latency: SHALL make a brightness register update visible on the 3rd clk rising edge after data_rdy rises; led SHALL reflect it one clk later.
REQ-022 Abort: while synchronised nsel=1, SHALL force the FSM to IDLE; a partial command SHALL be dropped without writes or cmd_err.
REQ-023 Simultaneous nsel abort and byte_valid: abort SHALL win and the byte SHALL be dropped.
REQ-024 A new frame SHALL always start in IDLE; the first byte after nsel falls is a command byte.
REQ-025 SHALL run an 8-bit free-running pwm_cnt that increments every clk and wraps 255 -> 0.
REQ-026 SHALL register led[i] = (pwm_cnt < bright[i]) each clk; bright=0 gives always off, and bright=255 gives on for 255 of every 256 cycles.
REQ-027 Brightness writes SHALL take effect immediately (no wait for period end); glitch-free period alignment is not required.

Reset
REQ-028 While nreset=0, SHALL hold bright[*]=0, pwm_cnt=0, led=0, cmd_err=0, FSM=IDLE, data_rdy sync flops=0, nsel sync flops=1, latched addr=0.
REQ-029 Reset assertion mid-command SHALL discard the command; after release the FSM SHALL start in IDLE with no spurious byte_valid, even if data_rdy is high.

Structure
REQ-030 Shared package spi_led_pkg SHALL hold the opcode constants OP_NOP=00, OP_WRITE=01, OP_SET_ALL=10, OP_CLEAR=11, the FSM state encoding, and PWM_WIDTH=8.
REQ-031 SHALL instantiate sub-module sync_2ff (1-bit, parameterised reset value) for data_rdy and nsel.
REQ-032 The brightness register file, FSM and PWM SHALL remain in spi_led_ctrl; no other sub-modules.

Verification
REQ-033 Reset, then hold for 600 clk -> led=0 throughout, cmd_err never asserted.
REQ-034 nsel=0, bytes 0x43, 0x80 -> bright[3]=0x80; led[3] high exactly 128 of every 256 clk; other LEDs stay 0.
REQ-035 Bytes 0x80, 0xFF, then 0xC0 -> all LEDs high 255/256 cycles, then all led=0 from 1 clk after the CLEAR update.
REQ-036 NUM_LEDS=4, bytes 0x46, 0x55 -> one cmd_err pulse, no register changes, FSM back in IDLE.
REQ-037 Byte 0x42, then nsel=1, then nsel=0, then byte 0x81 -> bright[2] unchanged; 0x81 decoded as SET_ALL, waiting in ALL_DATA.
REQ-038 nreset pulsed low between 0x41 and its data byte -> all bright=0; the next byte 0x10 is decoded as NOP.
